// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction fetch stage with a 2-entry output buffer.
//
// Fetches one word per cycle from a combinational instruction ROM. Each
// fetched {pc, instr} pair is pushed into a 2-entry FIFO. The decode stage
// drains the FIFO through a valid/ready handshake. A redirect reloads the PC
// and flushes every buffered instruction.
//
// Optional feature (compile-time macro FETCH_ALIGN_CHECK_EN):
//   When defined, a redirect to a non-word-aligned target has these effects:
//   it raises the sticky misalign_err, flushes the FIFO, keeps the PC and
//   halts fetch. The next aligned redirect or a reset clears the error.
//   When undefined, misalign_err is tied low and the target is forced to word
//   alignment.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   synchronous active-low reset
//   imem_addr      out  byte address to the ROM (the PC register)
//   imem_data      in   ROM word at imem_addr, same cycle
//   redirect_valid in   taken branch/jump: load redirect_pc, flush
//   redirect_pc    in   redirect target byte address
//   out_valid      out  buffer head holds a valid instruction
//   out_ready      in   decode accepts the head this cycle
//   out_instr      out  instruction at the buffer head
//   out_pc         out  byte address of out_instr
//   misalign_err   out  misaligned-redirect flag (sticky)
module ifetch_unit #(
  parameter int          ADDR_WIDTH = 13,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  misalign_err
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));
  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC) & ALIGN_MASK;

  logic [ADDR_WIDTH-1:0] pc;
  logic [1:0]            count;
  // Entry 0 is the head and drives out_*. Entry 1 is the tail.
  logic [ADDR_WIDTH-1:0] pc_e0, pc_e1;
  logic [DATA_WIDTH-1:0] instr_e0, instr_e1;

  logic                  pop, push, misaligned, halted;
  logic [ADDR_WIDTH-1:0] target;

  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] cur);
    next_pc = cur + ADDR_WIDTH'(4);  // wraps modulo 2^ADDR_WIDTH
  endfunction

`ifdef FETCH_ALIGN_CHECK_EN
  logic err;
  assign misalign_err = err;
`else
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    target = redirect_pc & ALIGN_MASK;
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    halted     = err;
`else
    misaligned = 1'b0;
    halted     = 1'b0;
`endif
    pop  = (count != 2'd0) && out_ready;
    // A pop frees a slot in the same edge, so a full buffer still streams.
    push = ((count != 2'd2) || pop) && !redirect_valid && !halted;
  end

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = instr_e0;
  assign out_pc    = pc_e0;

  // Control state and buffer head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_ADDR;
      count    <= 2'd0;
      pc_e0    <= '0;
      instr_e0 <= '0;
    end else if (redirect_valid) begin
      // A flush discards everything, including any head accepted this edge.
      count <= 2'd0;
      if (!misaligned) pc <= target;
    end else begin
      if (push) pc <= next_pc(pc);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (pop && count == 2'd2) begin
        pc_e0    <= pc_e1;
        instr_e0 <= instr_e1;
      end else if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
        pc_e0    <= pc;
        instr_e0 <= imem_data;
      end
    end
  end

  // Buffer tail: written when the new word lands behind a live head.
  always_ff @(posedge clk) begin
    if (push && ((count == 2'd2 && pop) || (count == 2'd1 && !pop))) begin
      pc_e1    <= pc;
      instr_e1 <= imem_data;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)              err <= 1'b0;
    else if (redirect_valid) err <= misaligned;
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. The DUT uses default parameters.
// The ROM returns the word index (ROM[i] = i).
// The reference model keeps the expected buffer contents as a queue of fetch
// addresses and applies the fetch, redirect and reset rules at each edge.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [12:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [12:0] out_pc;
  logic        misalign_err;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [12:0] m_pc;
  logic [12:0] m_q[$];
  logic        m_err;
  logic        m_in_reset;

  ifetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  assign imem_data = 32'(imem_addr >> 2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the model's view of one rising edge with the given inputs.
  task automatic model_edge(input logic rn, input logic rv, input logic [12:0] rpc,
                            input logic rdy);
    int  pre;
    bit  did_pop;
    m_in_reset = !rn;
    if (!rn) begin
      m_pc  = 13'h0;
      m_q.delete();
      m_err = 1'b0;
    end else if (rv) begin
      m_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) m_err = 1'b1;
      else begin m_err = 1'b0; m_pc = rpc; end
`else
      m_pc = {rpc[12:2], 2'b00};
`endif
    end else begin
      pre     = m_q.size();
      did_pop = (pre > 0) && rdy;
      if (did_pop) void'(m_q.pop_front());
      if ((pre < 2 || did_pop) && !m_err) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 13'd4;
      end
    end
  endtask

  task automatic check_all();
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("imem_addr", 32'(imem_addr), 32'(m_pc));
    check("misalign_err", 32'(misalign_err), 32'(m_err));
    if (m_q.size() != 0) begin
      check("out_pc", 32'(out_pc), 32'(m_q[0]));
      check("out_instr", out_instr, 32'(m_q[0] >> 2));
    end
    if (m_in_reset) begin
      check("rst_out_pc", 32'(out_pc), 32'h0);
      check("rst_out_instr", out_instr, 32'h0);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge occur, then check.
  task automatic cycle(input logic rn, input logic rv, input logic [12:0] rpc,
                       input logic rdy);
    rst_n          = rn;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    model_edge(rn, rv, rpc, rdy);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 13'h0;
    out_ready      = 1'b0;
    m_pc           = 13'h0;
    m_err          = 1'b0;
    m_in_reset     = 1'b1;
    @(negedge clk);

    // Reset overrides a redirect and a ready decoder.
    cycle(1'b0, 1'b1, 13'h0400, 1'b1);
    cycle(1'b0, 1'b1, 13'h0400, 1'b1);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_addr", 32'(imem_addr), 32'h0);

    // Stream from reset, one instruction per cycle.
    cycle(1'b1, 1'b0, 13'h0, 1'b1);
    check("first_pc", 32'(out_pc), 32'h0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 13'h0, 1'b1);
    check("stream_pc", 32'(out_pc), 32'h018);

    // Stall from reset: the buffer fills, then drains without a gap.
    cycle(1'b0, 1'b0, 13'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 13'h0, 1'b0);
    check("stall_addr", 32'(imem_addr), 32'h008);
    check("stall_pc", 32'(out_pc), 32'h000);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 13'h0, 1'b1);

    // Redirect while streaming, including a handshake on the redirect edge.
    cycle(1'b1, 1'b1, 13'h0100, 1'b1);
    check("redir_gap", 32'(out_valid), 32'h0);
    cycle(1'b1, 1'b0, 13'h0, 1'b1);
    check("redir_pc", 32'(out_pc), 32'h100);
    check("redir_instr", out_instr, 32'h40);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 13'h0, 1'b1);

    // Wrap at the top of the address space.
    cycle(1'b1, 1'b1, 13'h1FF8, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 13'h0, 1'b1);

    // Misaligned redirect followed by an aligned one.
    cycle(1'b1, 1'b1, 13'h0102, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 13'h0, 1'b1);
    cycle(1'b1, 1'b1, 13'h0200, 1'b1);
    cycle(1'b1, 1'b0, 13'h0, 1'b1);
    check("realign_pc", 32'(out_pc), 32'h200);
    cycle(1'b1, 1'b0, 13'h0, 1'b1);

    // Back-to-back redirects: the last one wins.
    cycle(1'b1, 1'b1, 13'h0300, 1'b1);
    cycle(1'b1, 1'b1, 13'h0500, 1'b1);
    cycle(1'b1, 1'b0, 13'h0, 1'b1);
    check("b2b_pc", 32'(out_pc), 32'h500);

    // Reset with a full buffer and a redirect pending.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 13'h0, 1'b0);
    cycle(1'b0, 1'b1, 13'h0700, 1'b1);
    check("rst_full_valid", 32'(out_valid), 32'h0);
    check("rst_full_addr", 32'(imem_addr), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        rn, rv, rdy;
      logic [12:0] rpc;
      rn  = ($urandom_range(99) >= 2);
      rv  = ($urandom_range(99) < 8);
      rdy = ($urandom_range(99) < 70);
      rpc = 13'($urandom);
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      cycle(rn, rv, rpc, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13: byte-address width of the instruction memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0: fetch address after reset; word-aligned.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port imem_addr, output, ADDR_WIDTH: byte address to the combinational instruction ROM; equals the internal PC register.
REQ-007 SHALL have port imem_data, input, DATA_WIDTH: ROM word at imem_addr, valid in the same cycle.
REQ-008 SHALL have port redirect_valid, input, 1: branch/jump taken; load redirect_pc and flush.
REQ-009 SHALL have port redirect_pc, input, ADDR_WIDTH: redirect target byte address.
REQ-010 SHALL have port out_valid, output, 1: out_instr/out_pc hold a valid fetched instruction.
REQ-011 SHALL have port out_ready, input, 1: decode accepts; transfer occurs on out_valid && out_ready.
REQ-012 SHALL have port out_instr, output, DATA_WIDTH: instruction at the buffer head.
REQ-013 SHALL have port out_pc, output, ADDR_WIDTH: byte address of out_instr.
REQ-014 SHALL have port misalign_err, output, 1: misaligned redirect flag (see Configuration).

Function
REQ-015 SHALL hold a PC register and a 2-entry FIFO of {pc, instr} pairs; out_* SHALL be driven from the FIFO head, registered (no combinational path from imem_data to out_*).
REQ-016 SHALL push {pc, imem_data} and advance PC by 4 on an edge when (count < 2 or a pop occurs that edge), no redirect is present, and fetch is not halted.
REQ-017 SHALL pop the head on every edge with out_valid && out_ready; out_valid SHALL equal (count != 0).
REQ-018 SHALL support simultaneous push and pop when full: count stays 2, order preserved, no bubble.
REQ-019 SHALL give sustained throughput of one instruction per cycle while out_ready is held high.
REQ-020 On redirect_valid, SHALL load PC with the target, empty the FIFO and suppress that edge's push; a handshake in the same cycle SHALL count as consumed.
REQ-021 Redirect latency: out_valid SHALL be low in the cycle after the redirect edge and high with out_pc = target in the following cycle (2 cycles from redirect to valid).
REQ-022 SHALL give redirect priority over push and pop-driven advance; back-to-back redirects SHALL each take effect, the last one winning.
REQ-023 SHALL wrap PC modulo 2^ADDR_WIDTH (e.g. 0x1FFC + 4 -> 0x0000 at ADDR_WIDTH=13).
REQ-024 SHALL keep out_instr/out_pc stable while out_valid && !out_ready.
REQ-025 SHALL keep PC bits [1:0] at 0 at all times.

Reset
REQ-026 While rst_n is low at an edge: PC = RESET_PC, FIFO empty, out_valid = 0, out_instr = 0, out_pc = 0, misalign_err = 0.
REQ-027 Reset SHALL override redirect and handshake in the same cycle; the first out_valid SHALL appear one cycle after the first edge with rst_n high.
REQ-028 Reset asserted mid-stream SHALL discard all buffered instructions.

Configuration
REQ-029 Macro FETCH_ALIGN_CHECK_EN: when defined, a redirect with redirect_pc[1:0] != 0 SHALL set misalign_err (sticky), flush the FIFO, leave PC unchanged and halt pushes; the next aligned redirect or reset SHALL clear it and resume fetch.
REQ-030 Without FETCH_ALIGN_CHECK_EN, misalign_err SHALL be tied 0 and redirect_pc[1:0] SHALL be ignored (target forced to word alignment).

Verification
REQ-031 Reset release, out_ready=1, ROM[i]=i -> out_pc 0x000,0x004,0x008... one per cycle, out_instr 0,1,2...
REQ-032 out_ready=0 for 5 cycles from reset -> out_valid=1, count 2, out_pc stays 0x000; imem_addr stays 0x008; on release, 0x000,0x004,0x008 emitted with no gap.
REQ-033 Redirect to 0x100 while streaming -> out_valid 0 next cycle, then out_pc=0x100 with out_instr=ROM[0x40]; no stale pre-redirect instruction emitted.
REQ-034 Redirect to 0x1FF8 -> out_pc 0x1FF8, 0x1FFC, 0x0000.
REQ-035 With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> misalign_err=1, out_valid stays 0; then redirect to 0x200 -> misalign_err=0, out_pc=0x200 two cycles later.
REQ-036 Reset asserted with FIFO full and redirect_valid=1 -> next cycle out_valid=0, imem_addr=RESET_PC.
